// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: result-bus payload type and lane count shared by
// the common-data-bus arbiter and its round-robin picker.
package cdb_arbiter_pkg;

    localparam int XLEN      = 32;
    localparam int REG_W     = 6;
    localparam int CDB_LANES = 2;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  address;
        logic [REG_W-1:0] arn;
        logic [REG_W-1:0] rrn;
        logic             jmp;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// cdb_arbiter_rr_pick2: combinational round-robin picker that selects
// up to two requesters, scanning upward from the pointer with wrap.
module cdb_arbiter_rr_pick2 #(
    parameter int REQ_CNT = 4,
    parameter int SRC_W   = $clog2(REQ_CNT)
) (
    input  logic [REQ_CNT-1:0] i_req,
    input  logic [SRC_W-1:0]   i_rr_ptr,
    output logic [REQ_CNT-1:0] o_grant,
    output logic [SRC_W-1:0]   o_idx0,
    output logic [SRC_W-1:0]   o_idx1,
    output logic [1:0]         o_cnt
);

    logic [31:0]      w_pos;
    logic [SRC_W-1:0] w_sel;

    always_comb begin
        o_grant = '0;
        o_idx0  = '0;
        o_idx1  = '0;
        o_cnt   = 2'd0;
        w_pos   = '0;
        w_sel   = '0;
        for (int k = 0; k < REQ_CNT; k++) begin
            // position k in scan order, wrapped past the last unit
            w_pos = 32'(i_rr_ptr) + 32'(k);
            if (w_pos >= 32'(REQ_CNT)) begin
                w_pos = w_pos - 32'(REQ_CNT);
            end
            w_sel = w_pos[SRC_W-1:0];
            if (i_req[w_sel] && (o_cnt != 2'd2)) begin
                o_grant[w_sel] = 1'b1;
                if (o_cnt == 2'd0) begin
                    o_idx0 = w_sel;
                end else begin
                    o_idx1 = w_sel;
                end
                o_cnt = o_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to two execution units per cycle and
// registers their results onto the two common-data-bus lanes.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int REQ_CNT = 4,
    localparam int SRC_W  = $clog2(REQ_CNT)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                clear,
    input  logic [REQ_CNT-1:0]                  req,
    input  cdb_entry_t [REQ_CNT-1:0]            req_entry,
    output logic [REQ_CNT-1:0]                  grant,
    output logic [CDB_LANES-1:0]                lane_valid,
    output cdb_entry_t [CDB_LANES-1:0]          lane_entry,
    output logic [CDB_LANES-1:0][SRC_W-1:0]     lane_src
);

    logic [SRC_W-1:0]                 r_rr_ptr;
    logic [CDB_LANES-1:0]             r_lane_valid;
    cdb_entry_t [CDB_LANES-1:0]       r_lane_entry;
    logic [CDB_LANES-1:0][SRC_W-1:0]  r_lane_src;

    logic [REQ_CNT-1:0] w_pick;
    logic [SRC_W-1:0]   w_idx0;
    logic [SRC_W-1:0]   w_idx1;
    logic [SRC_W-1:0]   w_last;
    logic [SRC_W-1:0]   w_next_ptr;
    logic [1:0]         w_cnt;
    logic               w_fire;

    cdb_arbiter_rr_pick2 #(
        .REQ_CNT (REQ_CNT),
        .SRC_W   (SRC_W)
    ) u_pick (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_pick),
        .o_idx0   (w_idx0),
        .o_idx1   (w_idx1),
        .o_cnt    (w_cnt)
    );

    // a flush or a held reset suppresses every grant this cycle
    assign w_fire     = reset && !clear;
    assign grant      = w_fire ? w_pick : '0;
    assign w_last     = (w_cnt == 2'd2) ? w_idx1 : w_idx0;
    assign w_next_ptr = (w_last == SRC_W'(REQ_CNT - 1)) ? '0
                      : w_last + SRC_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr     <= '0;
            r_lane_valid <= '0;
            r_lane_entry <= '0;
            r_lane_src   <= '0;
        end else if (clear) begin
            r_lane_valid <= '0;
        end else begin
            r_lane_valid    <= {w_cnt == 2'd2, w_cnt != 2'd0};
            r_lane_entry[0] <= req_entry[w_idx0];
            r_lane_entry[1] <= req_entry[w_idx1];
            r_lane_src[0]   <= w_idx0;
            r_lane_src[1]   <= w_idx1;
            if (w_cnt != 2'd0) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    assign lane_valid = r_lane_valid;
    assign lane_entry = r_lane_entry;
    assign lane_src   = r_lane_src;

    // one unit can never own both lanes at once
    a_distinct_src: assert property (@(posedge clock) disable iff (!reset)
        (&r_lane_valid) |-> (r_lane_src[0] != r_lane_src[1]));

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table, async-reset sequence and a
// randomized hold-until-grant stress run against a queue-based model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;

    logic                  clock;
    logic                  reset;
    logic                  clear;
    logic [N-1:0]          req;
    cdb_entry_t [N-1:0]    req_entry;
    logic [N-1:0]          grant;
    logic [1:0]            lane_valid;
    cdb_entry_t [1:0]      lane_entry;
    logic [1:0][1:0]       lane_src;

    cdb_arbiter #(.REQ_CNT(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .req        (req),
        .req_entry  (req_entry),
        .grant      (grant),
        .lane_valid (lane_valid),
        .lane_entry (lane_entry),
        .lane_src   (lane_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic cdb_entry_t pay(input int u);
        cdb_entry_t e;
        e.result  = (u == 1) ? 32'h1234 : 32'hAB00_0000 + 32'(u);
        e.address = 32'hAD00_0000 + 32'(u);
        e.arn     = 6'(u);
        e.rrn     = 6'(u + 8);
        e.jmp     = u[0];
        return e;
    endfunction

    // reference: list requesters in rotation order from p, take two
    function automatic void model_pick(input logic [N-1:0] r, input int p,
                                       output logic [N-1:0] g,
                                       output int a0, output int a1,
                                       output int n);
        int q[$];
        q = {};
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) q.push_back((p + k) % N);
        end
        n  = (q.size() > 2) ? 2 : q.size();
        a0 = (n > 0) ? q[0] : 0;
        a1 = (n > 1) ? q[1] : 0;
        g  = '0;
        for (int j = 0; j < n; j++) g[q[j]] = 1'b1;
    endfunction

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         clr;
        logic [N-1:0] g;
        logic [1:0]   lv;
        int           s0;
        int           s1;
    } vec_t;

    vec_t tv[9];

    logic [N-1:0] pend;
    cdb_entry_t   pl[N];
    int           wait_c[N];
    int           max_wait;
    int           mptr;
    int           seq;
    int           granted;
    int           seen;

    initial begin
        logic [N-1:0] eg;
        logic [1:0]   ev;
        int           a0, a1, n;
        logic         clr;

        tv[0] = '{1'b1, 4'b0010, 1'b0, 4'b0010, 2'b01, 1, 0};
        tv[1] = '{1'b1, 4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1};
        tv[2] = '{1'b0, 4'b1111, 1'b0, 4'b1100, 2'b11, 2, 3};
        tv[3] = '{1'b0, 4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1};
        tv[4] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'b01, 2, 0};
        tv[5] = '{1'b0, 4'b1011, 1'b0, 4'b1001, 2'b11, 3, 0};
        tv[6] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'b00, 0, 0};
        tv[7] = '{1'b0, 4'b1111, 1'b0, 4'b0110, 2'b11, 1, 2};
        tv[8] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'b00, 0, 0};

        reset = 1'b0;
        clear = 1'b0;
        req   = 4'b1111;
        for (int u = 0; u < N; u++) req_entry[u] = pay(u);

        #12;
        check("reset grant", 128'(grant), 128'(4'b0000));
        check("reset lane_valid", 128'(lane_valid), 128'(2'b00));
        check("reset lane_src", 128'(lane_src), 128'(4'b0000));
        check("reset lane_entry", 128'(lane_entry), 128'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        req   = '0;

        for (int i = 0; i < 9; i++) begin
            if (tv[i].rst) begin
                reset = 1'b0;
                #1;
                reset = 1'b1;
            end
            req   = tv[i].req;
            clear = tv[i].clr;
            @(negedge clock);
            check($sformatf("t%0d grant", i), 128'(grant), 128'(tv[i].g));
            @(posedge clock);
            #1;
            req   = '0;
            clear = 1'b0;
            check($sformatf("t%0d lane_valid", i), 128'(lane_valid),
                  128'(tv[i].lv));
            if (tv[i].lv[0]) begin
                check($sformatf("t%0d src0", i), 128'(lane_src[0]),
                      128'(tv[i].s0));
                check($sformatf("t%0d entry0", i), 128'(lane_entry[0]),
                      128'(pay(tv[i].s0)));
            end
            if (tv[i].lv[1]) begin
                check($sformatf("t%0d src1", i), 128'(lane_src[1]),
                      128'(tv[i].s1));
                check($sformatf("t%0d entry1", i), 128'(lane_entry[1]),
                      128'(pay(tv[i].s1)));
            end
        end

        // async reset between edges while both lanes are valid
        req = 4'b1111;
        @(negedge clock);
        check("ar grant", 128'(grant), 128'(4'b1001));
        @(posedge clock);
        #1;
        check("ar lanes up", 128'(lane_valid), 128'(2'b11));
        #2;
        reset = 1'b0;
        #1;
        check("ar lane_valid", 128'(lane_valid), 128'(2'b00));
        check("ar grant held", 128'(grant), 128'(4'b0000));
        check("ar lane_src", 128'(lane_src), 128'(4'b0000));
        check("ar lane_entry", 128'(lane_entry), 128'(0));
        reset = 1'b1;
        @(negedge clock);
        check("ar first grant", 128'(grant), 128'(4'b0011));
        @(posedge clock);
        #1;
        check("ar post src0", 128'(lane_src[0]), 128'(0));
        check("ar post src1", 128'(lane_src[1]), 128'(1));
        req  = '0;
        mptr = 2;

        // randomized stress, units hold payload until granted
        pend     = '0;
        max_wait = 0;
        seq      = 0;
        granted  = 0;
        seen     = 0;
        for (int u = 0; u < N; u++) wait_c[u] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int u = 0; u < N; u++) begin
                if (!pend[u] && ($urandom_range(0, 1) == 1)) begin
                    pend[u]          = 1'b1;
                    wait_c[u]        = 0;
                    pl[u].result     = {8'(u), 24'(seq)};
                    pl[u].address    = $urandom;
                    pl[u].arn        = 6'($urandom);
                    pl[u].rrn        = 6'($urandom);
                    pl[u].jmp        = 1'($urandom);
                    seq++;
                end
                req_entry[u] = pl[u];
            end
            clr   = ($urandom_range(0, 19) == 0);
            req   = pend;
            clear = clr;
            model_pick(pend, mptr, eg, a0, a1, n);
            if (clr) begin
                eg = '0;
                n  = 0;
            end
            ev = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
            @(negedge clock);
            check($sformatf("s%0d grant", c), 128'(grant), 128'(eg));
            if (!clr) begin
                for (int u = 0; u < N; u++) begin
                    if (pend[u]) begin
                        wait_c[u]++;
                        if (wait_c[u] > max_wait) max_wait = wait_c[u];
                    end
                end
            end
            if (n > 0) mptr = (((n == 2) ? a1 : a0) + 1) % N;
            @(posedge clock);
            #1;
            check($sformatf("s%0d lane_valid", c), 128'(lane_valid),
                  128'(ev));
            if (ev[0]) begin
                check($sformatf("s%0d src0", c), 128'(lane_src[0]),
                      128'(a0));
                check($sformatf("s%0d entry0", c), 128'(lane_entry[0]),
                      128'(pl[a0]));
            end
            if (ev[1]) begin
                check($sformatf("s%0d src1", c), 128'(lane_src[1]),
                      128'(a1));
                check($sformatf("s%0d entry1", c), 128'(lane_entry[1]),
                      128'(pl[a1]));
            end
            seen = seen + int'(lane_valid[0]) + int'(lane_valid[1]);
            for (int u = 0; u < N; u++) begin
                if (eg[u]) begin
                    pend[u] = 1'b0;
                    granted++;
                end
            end
        end
        req   = '0;
        clear = 1'b0;
        check("delivered count", 128'(seen), 128'(granted));
        check("max wait within 2", 128'(max_wait <= 2), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
